// File: rtl/nes_fb_pkg.sv
// ============================================================================
// Module  : nes_fb_pkg
// Brief   : Shared types and constants for the NES framebuffer bank controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nes_fb_pkg;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    FILL = 2'd1,
    PEND = 2'd2
  } state_t;

  typedef logic bank_t;

  localparam int FB_W = 256;
  localparam int FB_H = 240;

endpackage

`default_nettype wire

// File: rtl/nes_sat_counter.sv
// ============================================================================
// Module  : nes_sat_counter
// Brief   : Saturating up-counter; clear wins over a same-cycle increment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/nes_fb_bank_ctrl.sv
// ============================================================================
// Module  : nes_fb_bank_ctrl
// Brief   : Double-buffer bank scheduler for the NES framebuffer, tear-free swap
//           at display frame start. Optional stats counters: NES_FB_STATS_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_fb_bank_ctrl
  import nes_fb_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int STALE_FRAMES = 8
) (
  input  logic             clk_pixel,
  input  logic             rst_pixel,
  input  logic             wr_frame_start,
  input  logic             wr_frame_done,
  input  logic             rd_frame_start,
  output logic             wr_bank,
  output logic             wr_en,
  output logic             rd_bank,
  output logic             rd_valid,
  output logic             swap,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] repeat_cnt
);

  localparam logic [7:0] c_stale_lim = 8'(STALE_FRAMES);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       w_swap;
  logic       w_drop;
  logic       w_repeat;
  bank_t      r_wr_bank;
  bank_t      r_rd_bank;
  logic       r_wr_en;
  logic       r_rd_valid;
  logic       r_swap;
  logic [7:0] r_stale;
  logic [7:0] w_stale_inc;

  always_ff @(posedge clk_pixel or posedge rst_pixel) begin
    if (rst_pixel)
      r_state <= ARM;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ARM: begin
        w_drop = wr_frame_done;
        if (wr_frame_start)
          w_state_nxt = FILL;
      end
      FILL: begin
        // A restart pulse keeps FILL; done takes priority over a restart.
        if (wr_frame_done) begin
          if (rd_frame_start) begin
            w_swap      = 1'b1;
            w_state_nxt = ARM;
          end else begin
            w_state_nxt = PEND;
          end
        end
      end
      PEND: begin
        w_drop = wr_frame_done;
        if (rd_frame_start) begin
          w_swap      = 1'b1;
          w_state_nxt = wr_frame_start ? FILL : ARM;
        end
      end
      default: w_state_nxt = ARM;
    endcase
    w_repeat = rd_frame_start && !w_swap;
  end

  assign w_stale_inc = (r_stale == 8'hFF) ? r_stale : r_stale + 8'd1;

  always_ff @(posedge clk_pixel or posedge rst_pixel) begin
    if (rst_pixel) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b1;
      r_wr_en    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_swap     <= 1'b0;
      r_stale    <= 8'd0;
    end else begin
      r_wr_en <= (w_state_nxt == FILL);
      r_swap  <= w_swap;
      if (w_swap) begin
        r_wr_bank  <= r_rd_bank;
        r_rd_bank  <= r_wr_bank;
        r_rd_valid <= 1'b1;
        r_stale    <= 8'd0;
      end else if (w_repeat) begin
        r_stale <= w_stale_inc;
        // Writer has stopped delivering frames: blank rather than freeze.
        if (w_stale_inc >= c_stale_lim)
          r_rd_valid <= 1'b0;
      end
    end
  end

  assign wr_bank  = r_wr_bank;
  assign rd_bank  = r_rd_bank;
  assign wr_en    = r_wr_en;
  assign rd_valid = r_rd_valid;
  assign swap     = r_swap;

`ifdef NES_FB_STATS_EN
  nes_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk_pixel),
    .rst   (rst_pixel),
    .i_clr (stats_clr),
    .i_inc (w_drop),
    .o_cnt (drop_cnt)
  );

  nes_sat_counter #(.W(CNT_W)) u_repeat_cnt (
    .clk   (clk_pixel),
    .rst   (rst_pixel),
    .i_clr (stats_clr),
    .i_inc (w_repeat),
    .o_cnt (repeat_cnt)
  );
`else
  logic [2:0] w_stats_unused;
  assign w_stats_unused = {stats_clr, w_drop, w_repeat};
  assign drop_cnt       = '0;
  assign repeat_cnt     = '0;
`endif

endmodule

`default_nettype wire
